// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, 1-2 stop bits.
// Every bit is held for CLKS_PER_BIT clocks. A valid/ready handshake accepts one word per frame.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  if (CLKS_PER_BIT < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter combination");
  end

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = 4;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                 state;
  logic [CW-1:0]          baud;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   baud_end;
  logic                   accept;

  // Odd mode makes the total number of ones (data plus parity) odd.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign baud_end = (baud == BAUD_LAST);

  // Datapath: word and its parity captured at transfer, shifted once per data bit period.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      shreg   <= in_data;
      par_bit <= parity_of(in_data);
    end else if (state == DATA && baud_end) begin
      shreg <= shreg >> 1;
    end
  end

  // Control: frame sequencer with registered line and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= START;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud  <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        PAR: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= STOP;
            tx      <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= IDLE;
              tx      <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          baud    <= '0;
          bit_idx <= '0;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations driven side by side, checked every cycle against
// a frame-list model, plus literal waveform checks for the directed scenarios.
module tb_uart_tx_frame;

  localparam int P_CPB [4] = '{4, 2, 3, 1};
  localparam int P_DB  [4] = '{8, 8, 7, 8};
  localparam int P_PAR [4] = '{0, 2, 1, 0};
  localparam int P_SB  [4] = '{1, 1, 2, 1};

  logic       clk;
  logic [3:0] rst;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] tx;
  logic [8:0] in_data [4];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][7:0]), .busy(busy[0]), .done(done[0]), .tx(tx[0]));
  uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][7:0]), .busy(busy[1]), .done(done[1]), .tx(tx[1]));
  uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][6:0]), .busy(busy[2]), .done(done[2]), .tx(tx[2]));
  uart_tx_frame #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u3 (
    .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][7:0]), .busy(busy[3]), .done(done[3]), .tx(tx[3]));

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } ent_t;

  ent_t q [4][$];
  ent_t cur [4];
  bit   live [4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s time=%0t actual=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Whole frame as a list of per-cycle (tx, busy, done) values, ending with the done cycle.
  task automatic build_frame(input int i, input logic [8:0] d);
    int ones;
    logic pb;
    ones = 0;
    for (int b = 0; b < P_DB[i]; b++) ones += int'(d[b]);
    for (int k = 0; k < P_CPB[i]; k++) q[i].push_back('{1'b0, 1'b1, 1'b0});
    for (int b = 0; b < P_DB[i]; b++)
      for (int k = 0; k < P_CPB[i]; k++) q[i].push_back('{d[b], 1'b1, 1'b0});
    if (P_PAR[i] != 0) begin
      pb = (P_PAR[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      for (int k = 0; k < P_CPB[i]; k++) q[i].push_back('{pb, 1'b1, 1'b0});
    end
    for (int k = 0; k < P_SB[i] * P_CPB[i]; k++) q[i].push_back('{1'b1, 1'b1, 1'b0});
    q[i].push_back('{1'b1, 1'b0, 1'b1});
  endtask

  // Model advance on each edge, compare shortly after it.
  initial begin
    for (int i = 0; i < 4; i++) begin
      live[i] = 1'b0;
      cur[i]  = '{1'b1, 1'b0, 1'b0};
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rst[i]) begin
          q[i].delete();
          cur[i]  = '{1'b1, 1'b0, 1'b0};
          live[i] = 1'b1;
        end else if (live[i]) begin
          if (in_valid[i] && !cur[i].busy) build_frame(i, in_data[i]);
          if (q[i].size() > 0) cur[i] = q[i].pop_front();
          else cur[i] = '{1'b1, 1'b0, 1'b0};
        end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (live[i]) begin
          chk($sformatf("model_tx[%0d]", i), 32'(tx[i]), 32'(cur[i].tx));
          chk($sformatf("model_busy[%0d]", i), 32'(busy[i]), 32'(cur[i].busy));
          chk($sformatf("model_done[%0d]", i), 32'(done[i]), 32'(cur[i].done));
          chk($sformatf("model_in_ready[%0d]", i), 32'(in_ready[i]), 32'(!cur[i].busy && !rst[i]));
        end
      end
    end
  end

  logic obs_tx   [100];
  logic obs_busy [100];
  logic obs_done [100];
  logic obs_rdy  [100];

  task automatic sample(input int i, input int c);
    obs_tx[c]   = tx[i];
    obs_busy[c] = busy[i];
    obs_done[c] = done[i];
    obs_rdy[c]  = in_ready[i];
  endtask

  task automatic send(input int i, input logic [8:0] d, input bit hold);
    int k;
    @(negedge clk);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    k = 0;
    while (!in_ready[i] && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk($sformatf("send_timeout[%0d]", i), 32'(in_ready[i]), 32'd1);
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      in_valid[i] = 1'b0;
      sample(i, 1);
    end
  endtask

  task automatic observe(input int i, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      @(negedge clk);
      sample(i, c);
    end
  endtask

  function automatic int count_busy(input int from, input int to);
    int n;
    n = 0;
    for (int c = from; c <= to; c++) n += int'(obs_busy[c]);
    return n;
  endfunction

  initial begin
    logic [9:0] pat;
    int n;

    rst      = 4'hF;
    in_valid = 4'h0;
    for (int i = 0; i < 4; i++) in_data[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'hF);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    rst = 4'h0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'hF);

    // 8N1 at 4 clocks per bit, word 0xA5.
    send(0, 9'h0A5, 1'b0);
    observe(0, 2, 42);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int c = 1; c <= 40; c++) chk($sformatf("t1_tx_c%0d", c), 32'(obs_tx[c]), 32'(pat[(c - 1) / 4]));
    chk("t1_busy_cycles", 32'(count_busy(1, 42)), 32'd40);
    chk("t1_done_c41", 32'(obs_done[41]), 32'd1);
    chk("t1_done_c40", 32'(obs_done[40]), 32'd0);
    chk("t1_done_c42", 32'(obs_done[42]), 32'd0);

    // Even parity, 2 clocks per bit: parity occupies cycles 19-20.
    send(1, 9'h007, 1'b0);
    observe(1, 2, 24);
    chk("t2_parity_07", 32'(obs_tx[19]), 32'd1);
    chk("t2_busy_cycles", 32'(count_busy(1, 24)), 32'd22);
    chk("t2_done_c23", 32'(obs_done[23]), 32'd1);
    send(1, 9'h003, 1'b0);
    observe(1, 2, 24);
    chk("t2_parity_03", 32'(obs_tx[20]), 32'd0);

    // 7O2 at 3 clocks per bit: parity cycles 25-27, stop cycles 28-33, done at 34.
    send(2, 9'h07F, 1'b0);
    observe(2, 2, 35);
    chk("t3_parity_7f", 32'(obs_tx[26]), 32'd0);
    n = 0;
    for (int c = 28; c <= 33; c++) n += int'(obs_tx[c]);
    chk("t3_stop_high", 32'(n), 32'd6);
    chk("t3_busy_cycles", 32'(count_busy(1, 35)), 32'd33);
    chk("t3_done_c34", 32'(obs_done[34]), 32'd1);

    // Back-to-back with valid held; in_data changes mid-frame.
    send(0, 9'h055, 1'b1);
    for (int c = 1; c <= 83; c++) begin
      @(negedge clk);
      if (c == 10) in_data[0] = 9'h00F;
      if (c == 42) in_valid[0] = 1'b0;
      sample(0, c);
    end
    n = 0;
    for (int c = 1; c <= 40; c++) n += int'(obs_rdy[c]);
    for (int c = 42; c <= 81; c++) n += int'(obs_rdy[c]);
    chk("t4_ready_low_in_frames", 32'(n), 32'd0);
    chk("t4_ready_c41", 32'(obs_rdy[41]), 32'd1);
    chk("t4_gap_tx_c41", 32'(obs_tx[41]), 32'd1);
    chk("t4_done_c41", 32'(obs_done[41]), 32'd1);
    chk("t4_start2_c42", 32'(obs_tx[42]), 32'd0);
    chk("t4_w1_bit2", 32'(obs_tx[13]), 32'd1);
    chk("t4_w1_bit3", 32'(obs_tx[17]), 32'd0);
    chk("t4_w2_bit0", 32'(obs_tx[46]), 32'd1);
    chk("t4_w2_bit4", 32'(obs_tx[62]), 32'd0);
    chk("t4_done_c82", 32'(obs_done[82]), 32'd1);

    // One-clock reset in the middle of DATA.
    send(0, 9'h03C, 1'b0);
    n = 0;
    for (int c = 2; c <= 60; c++) begin
      @(negedge clk);
      if (c == 10) rst[0] = 1'b1;
      if (c == 11) begin
        rst[0] = 1'b0;
        #1;
        chk("t5_tx_after_rst", 32'(tx[0]), 32'd1);
        chk("t5_busy_after_rst", 32'(busy[0]), 32'd0);
        chk("t5_ready_after_rst", 32'(in_ready[0]), 32'd1);
      end
      n += int'(done[0]);
    end
    chk("t5_no_done", 32'(n), 32'd0);
    send(0, 9'h0C3, 1'b0);
    observe(0, 2, 42);
    chk("t5_refill_busy", 32'(count_busy(1, 42)), 32'd40);
    chk("t5_refill_done", 32'(obs_done[41]), 32'd1);

    // One clock per bit, all-zero word.
    send(3, 9'h000, 1'b0);
    observe(3, 2, 12);
    n = 0;
    for (int c = 1; c <= 9; c++) n += int'(!obs_tx[c]);
    chk("t6_low_run", 32'(n), 32'd9);
    chk("t6_stop_c10", 32'(obs_tx[10]), 32'd1);
    chk("t6_busy_cycles", 32'(count_busy(1, 12)), 32'd10);
    chk("t6_done_c11", 32'(obs_done[11]), 32'd1);

    // Randomised traffic on all four configurations.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        rst[i] = ($urandom_range(0, 299) == 0);
        if (!in_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            in_valid[i] = 1'b1;
            in_data[i]  = 9'($urandom_range(0, 511));
          end
        end else begin
          if ($urandom_range(0, 3) == 0) in_data[i] = 9'($urandom_range(0, 511));
          if (!busy[i] && $urandom_range(0, 1) == 0) in_valid[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
    rst      = 4'h0;
    in_valid = 4'h0;
    repeat (60) @(negedge clk);
    chk("final_idle_busy", 32'(busy), 32'h0);
    chk("final_idle_tx", 32'(tx), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
